// File: rtl/sb_unpack_ctrl.sv
// Sequencer that streams packed words into a 2-row unpacker and steps a bit pointer per value.
// Reads one word at a time, at most two rows ahead; values are held stable while i_rdy is low.
module sb_unpack_ctrl #(
  parameter int N          = 16,
  parameter int SHIFT_BITS = 5,
  parameter int AW         = 16,
  parameter int CW         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [4:0]            i_prec,
  input  logic [CW-1:0]         i_count,
  input  logic [AW-1:0]         i_base,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_req,
  output logic [AW-1:0]         o_rd_addr,
  input  logic                  i_rd_vld,
  input  logic [N-1:0]          i_rd_data,
  output logic [1:0]            o_load,
  output logic [N-1:0]          o_data,
  output logic [SHIFT_BITS-1:0] o_s,
  output logic [N-1:0]          o_z,
  output logic                  o_vld,
  input  logic                  i_rdy
);

  localparam int LOGN = $clog2(N);
  localparam int PW   = CW + LOGN;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [SHIFT_BITS-1:0] prec_q, prec_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         words_q, words_d;
  logic [CW-1:0]         req_q, req_d;
  logic [CW-1:0]         loaded_q, loaded_d;
  logic [CW-1:0]         acc_q, acc_d;
  logic [AW-1:0]         base_q, base_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  outst_q, outst_d;
  logic                  rd_req_q, rd_req_d;

  logic [CW-1:0]         cur_j;
  logic [LOGN-1:0]       cur_off;
  logic                  span;
  logic [CW:0]           need;
  logic                  vld;
  logic                  accept;
  logic                  ld;
  logic                  rd_ok;
  logic [SHIFT_BITS-1:0] start_prec;
  logic [PW-1:0]         start_bits;

  always_comb begin
    cur_j   = ptr_q[PW-1:LOGN];
    cur_off = ptr_q[LOGN-1:0];
    span    = (int'(cur_off) + int'(prec_q)) > N;
    need    = {1'b0, cur_j} + (CW+1)'(1) + (CW+1)'(span);
    vld     = (state_q == RUN) && ({1'b0, loaded_q} >= need);
    accept  = vld && i_rdy;
    ld      = (state_q == RUN) && outst_q && i_rd_vld;
    // Word j+2 shares a row with word j, so it waits until value pointer leaves word j.
    rd_ok   = (state_q == RUN) && !outst_q && (req_q < words_q) &&
              ({1'b0, req_q} <= {1'b0, cur_j} + (CW+1)'(1));

    if (i_prec == 5'd0 || int'(i_prec) > N) begin
      start_prec = SHIFT_BITS'(N);
    end else begin
      start_prec = SHIFT_BITS'(i_prec);
    end
    start_bits = PW'(i_count) * PW'(start_prec);
  end

  always_comb begin
    state_d  = state_q;
    prec_d   = prec_q;
    count_d  = count_q;
    words_d  = words_q;
    req_d    = req_q;
    loaded_d = loaded_q;
    acc_d    = acc_q;
    base_d   = base_q;
    addr_d   = addr_q;
    ptr_d    = ptr_q;
    outst_d  = outst_q;
    rd_req_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          prec_d   = start_prec;
          count_d  = i_count;
          base_d   = i_base;
          words_d  = start_bits[PW-1:LOGN] + CW'(|start_bits[LOGN-1:0]);
          req_d    = '0;
          loaded_d = '0;
          acc_d    = '0;
          ptr_d    = '0;
          outst_d  = 1'b0;
          state_d  = (i_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rd_ok) begin
          rd_req_d = 1'b1;
          addr_d   = base_q + AW'(req_q);
          req_d    = req_q + CW'(1);
          outst_d  = 1'b1;
        end
        if (ld) begin
          loaded_d = loaded_q + CW'(1);
          outst_d  = 1'b0;
        end
        if (accept) begin
          ptr_d = ptr_q + PW'(prec_q);
          acc_d = acc_q + CW'(1);
          if (acc_q == count_q - CW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prec_q   <= '0;
      count_q  <= '0;
      words_q  <= '0;
      req_q    <= '0;
      loaded_q <= '0;
      acc_q    <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      ptr_q    <= '0;
      outst_q  <= 1'b0;
      rd_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prec_q   <= prec_d;
      count_q  <= count_d;
      words_q  <= words_d;
      req_q    <= req_d;
      loaded_q <= loaded_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      ptr_q    <= ptr_d;
      outst_q  <= outst_d;
      rd_req_q <= rd_req_d;
    end
  end

  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);
  assign o_rd_req  = rd_req_q;
  assign o_rd_addr = addr_q;
  assign o_load    = ld ? (loaded_q[0] ? 2'b10 : 2'b01) : 2'b00;
  assign o_data    = i_rd_data;
  assign o_vld     = vld;
  assign o_s       = vld ? SHIFT_BITS'({cur_j[0], cur_off}) : '0;
  assign o_z       = vld ? ~({N{1'b1}} << prec_q) : '0;

endmodule

// File: tb/tb_sb_unpack_ctrl.sv
// Bench for sb_unpack_ctrl: spec vectors, reset corner case and random transactions
// checked against a bit-stream reference of the packed words.
module tb_sb_unpack_ctrl;
  localparam int N  = 16;
  localparam int SB = 5;
  localparam int AW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [4:0]    i_prec = '0;
  logic [CW-1:0] i_count = '0;
  logic [AW-1:0] i_base = '0;
  logic          o_busy, o_done, o_rd_req, o_vld;
  logic [AW-1:0] o_rd_addr;
  logic          i_rd_vld = 1'b0;
  logic [N-1:0]  i_rd_data = '0;
  logic [1:0]    o_load;
  logic [N-1:0]  o_data, o_z;
  logic [SB-1:0] o_s;
  logic          i_rdy = 1'b0;

  always #5 clk = ~clk;

  sb_unpack_ctrl #(.N(N), .SHIFT_BITS(SB), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_prec(i_prec), .i_count(i_count),
    .i_base(i_base), .o_busy(o_busy), .o_done(o_done), .o_rd_req(o_rd_req),
    .o_rd_addr(o_rd_addr), .i_rd_vld(i_rd_vld), .i_rd_data(i_rd_data), .o_load(o_load),
    .o_data(o_data), .o_s(o_s), .o_z(o_z), .o_vld(o_vld), .i_rdy(i_rdy)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [15:0] memw [0:63];
  int obs_s[$];
  int obs_z[$];
  int n_reads;
  int first_addr;

  // Runs one transaction: bench acts as memory and consumer, checking every value
  // against the packed bit stream.
  task automatic run_txn(input int prec, input int cnt, input int base, input int lat,
                         input int mode);
    int peff, w, nreq, loaded, acc, acc_pre, pend, pend_idx, cyc, last_acc, stall_left;
    int need, done_cyc;
    bit done_seen, prev_stall, resp_now;
    logic [SB-1:0] prev_s;
    logic [15:0] prev_z, emask, ev;
    logic [31:0] r;
    logic [63:0] rr;
    peff = (prec == 0 || prec > N) ? N : prec;
    w = (cnt * peff + N - 1) / N;
    emask = 16'((1 << peff) - 1);
    for (int i = 0; i < 64; i++) memw[i] = 16'($urandom);
    obs_s.delete(); obs_z.delete();
    nreq = 0; loaded = 0; acc = 0; pend = -1; pend_idx = 0; last_acc = 0;
    stall_left = 5; done_seen = 0; prev_stall = 0; done_cyc = -1; first_addr = -1;
    prev_s = '0; prev_z = '0; r = '0;
    @(negedge clk);
    i_start = 1; i_prec = 5'(prec); i_count = CW'(cnt); i_base = AW'(base);
    i_rd_vld = 0; i_rdy = 0;
    @(negedge clk);
    i_start = 0;
    cyc = 1;
    while (!done_seen && cyc < 600) begin
      i_rd_vld = 0;
      resp_now = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          i_rd_vld = 1; i_rd_data = memw[pend_idx & 63]; pend = -1; resp_now = 1;
        end
      end
      case (mode)
        0: i_rdy = 1;
        1: i_rdy = 1'($urandom_range(0, 1));
        default: i_rdy = (stall_left == 0);
      endcase
      i_start = (mode == 1) && ($urandom_range(0, 7) == 0);
      acc_pre = acc;
      #1;
      if (o_done) begin done_seen = 1; done_cyc = cyc; end
      if (o_rd_req) begin
        chk("rd_single", (pend != -1) || resp_now, 0);
        chk("rd_addr", o_rd_addr, (base + nreq) & 'hFFFF);
        chk("rd_beyond", nreq < w, 1);
        if (nreq == 0) first_addr = o_rd_addr;
        pend = lat; pend_idx = nreq; nreq++;
      end
      if (i_rd_vld) begin
        chk("load_row", o_load, (loaded % 2 == 0) ? 1 : 2);
        chk("load_data", o_data, i_rd_data);
      end
      if (o_vld) begin
        need = (acc * peff + peff - 1) / N + 1;
        chk("vld_ready", (loaded >= need) && (acc < cnt), 1);
        if (prev_stall) begin
          chk("stall_s", o_s, prev_s);
          chk("stall_z", o_z, prev_z);
        end
        if (i_rdy) begin
          chk("s", o_s, ((acc * peff / N) % 2) * N + (acc * peff) % N);
          chk("z", o_z, emask);
          rr = {r, r} >> o_s;
          ev = '0;
          for (int i = 0; i < peff; i++) begin
            int b;
            b = acc * peff + i;
            ev[i] = memw[(b / N) & 63][b % N];
          end
          chk("value", rr[15:0] & o_z, ev);
          obs_s.push_back(int'(o_s)); obs_z.push_back(int'(o_z));
          acc++; last_acc = cyc;
        end
      end else if (prev_stall) begin
        chk("stall_vld", o_vld, 1);
      end
      prev_stall = o_vld && !i_rdy;
      prev_s = o_s; prev_z = o_z;
      if (o_vld && !i_rdy && stall_left > 0) stall_left--;
      if (o_load[0]) r[15:0] = o_data;
      if (o_load[1]) r[31:16] = o_data;
      if (i_rd_vld) begin
        loaded++;
        chk("resident", (loaded - acc_pre * peff / N) <= 2, 1);
      end
      @(negedge clk);
      cyc++;
    end
    i_start = 0; i_rd_vld = 0; i_rdy = 0;
    #1;
    chk("done_seen", done_seen, 1);
    chk("n_reads", nreq, w);
    chk("n_vals", acc, cnt);
    chk("done_time", done_cyc, (cnt == 0) ? 1 : last_acc + 1);
    chk("idle_busy", o_busy, 0);
    chk("done_pulse", o_done, 0);
    n_reads = nreq;
    if (!done_seen) begin
      rst_n = 0; @(negedge clk); rst_n = 1;
    end
  endtask

  typedef struct {
    int prec; int cnt; int base; int lat; int mode; int exp_w;
    logic [0:5][5:0] exp_s; int exp_z;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int t;
    tbl[0] = '{16, 3, 'h10, 1, 0, 3, {6'd0, 6'd16, 6'd0, 6'd0, 6'd0, 6'd0}, 'hFFFF};
    tbl[1] = '{5, 6, 'h20, 2, 0, 2, {6'd0, 6'd5, 6'd10, 6'd15, 6'd20, 6'd25}, 'h001F};
    tbl[2] = '{12, 4, 'h30, 1, 0, 3, {6'd0, 6'd12, 6'd24, 6'd4, 6'd0, 6'd0}, 'h0FFF};
    tbl[3] = '{12, 4, 'h40, 3, 2, 3, {6'd0, 6'd12, 6'd24, 6'd4, 6'd0, 6'd0}, 'h0FFF};
    tbl[4] = '{0, 3, 'h50, 1, 0, 3, {6'd0, 6'd16, 6'd0, 6'd0, 6'd0, 6'd0}, 'hFFFF};
    tbl[5] = '{0, 0, 'h60, 1, 0, 0, {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0}, 'hFFFF};
    tbl[6] = '{20, 2, 'h68, 2, 1, 2, {6'd0, 6'd16, 6'd0, 6'd0, 6'd0, 6'd0}, 'hFFFF};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {o_busy, o_done, o_rd_req, o_vld, o_load, o_s, o_z, o_rd_addr}, 0);
    @(negedge clk);
    rst_n = 1;

    for (int v = 0; v < 7; v++) begin
      run_txn(tbl[v].prec, tbl[v].cnt, tbl[v].base, tbl[v].lat, tbl[v].mode);
      chk("tbl_words", n_reads, tbl[v].exp_w);
      for (int k = 0; k < tbl[v].cnt && k < 6; k++) begin
        chk("tbl_s", (k < obs_s.size()) ? obs_s[k] : -1, tbl[v].exp_s[k]);
      end
      if (tbl[v].cnt > 0) chk("tbl_z", (obs_z.size() > 0) ? obs_z[0] : -1, tbl[v].exp_z);
    end

    // Reset with a read in flight, then a stray read response while idle.
    @(negedge clk);
    i_start = 1; i_prec = 5'd16; i_count = CW'(4); i_base = AW'('h70);
    @(negedge clk);
    i_start = 0;
    t = 0;
    while (!o_rd_req && t < 20) begin @(negedge clk); t++; end
    chk("rst_req_seen", o_rd_req, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_mid_outputs", {o_busy, o_done, o_rd_req, o_vld, o_load, o_s, o_z}, 0);
    @(negedge clk);
    rst_n = 1; i_rd_vld = 1; i_rd_data = 16'hBEEF;
    #1;
    chk("late_load", o_load, 0);
    chk("late_busy", o_busy, 0);
    @(negedge clk);
    i_rd_vld = 0;
    run_txn(16, 3, 'h80, 2, 0);
    chk("restart_addr", first_addr, 'h80);

    for (int n = 0; n < 25; n++) begin
      run_txn($urandom_range(0, 20), $urandom_range(0, 12), $urandom_range(0, 'hFFF0),
              $urandom_range(1, 4), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sb_unpack_ctrl.md
SB_UNPACK_CTRL -- requirements
Module: sb_unpack_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning packed word width and unpacked value width.
REQ-002 The block SHALL have parameter SHIFT_BITS, default 5, meaning the width of o_s, equal to log2(2*N).
REQ-003 The block SHALL have parameter AW, default 16, meaning the width of the synapse-buffer read address.
REQ-004 The block SHALL have parameter CW, default 16, meaning the width of the value count.
REQ-005 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; sampled in IDLE only
- i_prec  in  5  precision P in bits per value, valid range 1..N
- i_count  in  CW  number of values to unpack
- i_base  in  AW  address of first packed word
- o_busy  out  1  high from accepted start until done
- o_done  out  1  one-cycle completion pulse
- o_rd_req  out  1  one-cycle read request pulse
- o_rd_addr  out  AW  read address, valid with o_rd_req
- i_rd_vld  in  1  read data valid
- i_rd_data  in  N  read data
- o_load  out  2  unpacker row load; bit0 = LS row, bit1 = MS row
- o_data  out  N  row data to the unpacker
- o_s  out  SHIFT_BITS  unpacker rotate amount
- o_z  out  N  zero-extension mask
- o_vld  out  1  o_s/o_z describe a valid value
- i_rdy  in  1  downstream accepts the value

Function
REQ-006 Downstream model: 2N-bit register R; o_load[0] writes R[N-1:0], o_load[1] writes R[2N-1:N]; value = (R rotated right by o_s)[N-1:0] & o_z.
REQ-007 Precision: P = i_prec, latched at start; i_prec of 0 or greater than N SHALL be treated as P = N.
REQ-008 Value k SHALL occupy stream bits k*P .. k*P+P-1, LSB first; word j = b/N, offset off = b mod N, where b = k*P.
REQ-009 Word count W = ceil(i_count*P/N), computed at start; word m SHALL be read from i_base+m, once, in order m = 0..W-1, and never beyond W-1.
REQ-010 Word m SHALL be loaded into row m mod 2: o_load[m mod 2] = i_rd_vld, o_data = i_rd_data, combinationally, in the i_rd_vld cycle.
REQ-011 For value k: o_s = ((j mod 2)*N + off) mod 2N; o_z = low P bits set, upper bits zero.
REQ-012 Reads: at most one outstanding; i_rd_vld arrives at least 1 cycle after o_rd_req; request word m only when m <= j+1 for the current value's j.
REQ-013 o_vld SHALL be high only when words_loaded >= j+1+span, where span = 1 if off+P > N, else 0.
REQ-014 A value is accepted on o_vld & i_rdy; the pointer then advances by P; freeing of row j enables the request for word j+2.
REQ-015 With i_rdy low, o_vld, o_s and o_z SHALL hold stable.
REQ-016 FSM states are IDLE, RUN and DONE:
- IDLE -> RUN on i_start
- RUN -> DONE when value i_count-1 is accepted
- DONE -> IDLE after one cycle, with o_done = 1 in DONE
REQ-017 i_count = 0 SHALL give no reads and no o_vld, with o_done one cycle after start.
REQ-018 i_start while busy SHALL be ignored; i_rd_vld in IDLE SHALL be ignored, with o_load = 0.
REQ-019 The pointer SHALL be at least log2(2^CW * N) bits wide, with no wrap for any legal count.

Reset
REQ-020 On rst_n low, asynchronously: state = IDLE; counters and pointer = 0; o_busy, o_done, o_rd_req, o_vld, o_load = 0; o_s = 0; o_z = 0.
REQ-021 On reset mid-operation, the in-flight read SHALL be discarded and the next start SHALL begin cleanly from word 0.

Verification
REQ-022 P=16, count=3, base=0x10 -> reads 0x10, 0x11, 0x12; o_s = 0, 16, 0; o_z = 0xFFFF; o_done after the third accept.
REQ-023 P=5, count=6 -> W=2; o_s = 0, 5, 10, 15, 20, 25; o_z = 0x001F; exactly 2 reads.
REQ-024 P=12, count=4 -> W=3; o_s = 0, 12, 24, 4; value 1 withheld until word 1 is loaded.
REQ-025 P=12 with i_rdy low 5 cycles and read latency 3 -> o_s/o_z stable while stalled; no more than 2 resident words ahead.
REQ-026 count=0 -> no o_rd_req, o_done one cycle after start; i_prec=0 -> behaves as P=16.
REQ-027 rst_n low with a read outstanding -> all outputs 0; a late i_rd_vld gives o_load = 0; restart reads from i_base.
